// File: rtl/product_accumulator.sv
// Accumulates a stream of signed products into one group sum. Each group is closed by
// in_last and held on a valid/ready output. The next group may start after the result is taken.
module product_accumulator #(
  parameter int IN_W  = 64,
  parameter int GUARD = 8,
  parameter int CNT_W = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           soft_clr,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [IN_W-1:0]         in_product,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [IN_W+GUARD-1:0]   out_sum,
  output logic        [CNT_W-1:0]        out_count,
  output logic                           out_ovf
);

  localparam int SUM_W = IN_W + GUARD;

  typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_e;

  state_e                   state_q;
  logic signed [SUM_W-1:0]  acc_q, acc_d, prod_ext;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic add_ovf(input logic signed [SUM_W-1:0] a,
                                   input logic signed [SUM_W-1:0] b,
                                   input logic signed [SUM_W-1:0] s);
    return (a[SUM_W-1] == b[SUM_W-1]) && (s[SUM_W-1] != a[SUM_W-1]);
  endfunction

  // in_ready must not look at in_valid, so it is built from state and soft_clr alone
  assign in_ready = (state_q == ACC) && !soft_clr;
  assign accept   = in_valid && in_ready;

  always_comb begin
    prod_ext = SUM_W'(in_product);
    acc_d    = acc_q + prod_ext;
    ovf_d    = ovf_q | add_ovf(acc_q, prod_ext, acc_d);
    cnt_d    = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (soft_clr) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end else if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (in_last) state_q <= OUT;
          end
        end
        OUT: begin
          // the held result is never discarded by soft_clr; only the consumer retires it
          if (out_ready) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign out_valid = (state_q == OUT);
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Random and directed stimulus for product_accumulator at GUARD=8 and GUARD=0, checked
// against a group-level reference model built from queues of accepted products.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n, soft_clr, in_valid, in_last, out_ready;
  logic signed [63:0] in_product;
  logic        in_ready8, out_valid8, ovf8, in_ready0, out_valid0, ovf0;
  logic signed [71:0] sum8;
  logic signed [63:0] sum0;
  logic [7:0]  cnt8, cnt0;

  int total = 0;
  int bad   = 0;

  product_accumulator #(.IN_W(64), .GUARD(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid), .in_ready(in_ready8),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid8), .out_ready(out_ready),
    .out_sum(sum8), .out_count(cnt8), .out_ovf(ovf8));

  product_accumulator #(.IN_W(64), .GUARD(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr), .in_valid(in_valid), .in_ready(in_ready0),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
    .out_sum(sum0), .out_count(cnt0), .out_ovf(ovf0));

  always #5 clk = ~clk;

  // reference model: products of the open group, plus the result being held
  longint             grp[$];
  bit                 m_out;
  bit                 m_took;
  logic signed [127:0] r_sum8, r_sum0;
  bit                 r_ovf8, r_ovf0;
  int                 r_cnt;

  task automatic chk(input string tag, input logic signed [127:0] got, input logic signed [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // sum the group exactly, wrapping into w bits after each add and flagging any out-of-range step
  task automatic eval_grp(input int w, output logic signed [127:0] s, output bit o);
    logic signed [127:0] exact, hi, lo;
    hi = (128'sd1 <<< (w - 1)) - 1;
    lo = -(128'sd1 <<< (w - 1));
    s = 0;
    o = 1'b0;
    foreach (grp[i]) begin
      exact = s + 128'(grp[i]);
      if (exact > hi || exact < lo) o = 1'b1;
      s = (exact <<< (128 - w)) >>> (128 - w);
    end
  endtask

  task automatic step();
    bit exp_ready;
    #4;
    exp_ready = !m_out && !soft_clr;
    chk("in_ready8", in_ready8, exp_ready);
    chk("in_ready0", in_ready0, exp_ready);
    @(posedge clk);
    m_took = exp_ready && in_valid;
    if (!m_out && soft_clr) grp.delete();
    else if (m_took) begin
      grp.push_back(in_product);
      if (in_last) begin
        eval_grp(72, r_sum8, r_ovf8);
        eval_grp(64, r_sum0, r_ovf0);
        r_cnt = (grp.size() > 255) ? 255 : grp.size();
        grp.delete();
        m_out = 1'b1;
      end
    end else if (m_out && out_ready) m_out = 1'b0;
    #1;
    chk("out_valid8", out_valid8, m_out);
    chk("out_valid0", out_valid0, m_out);
    if (m_out) begin
      chk("sum8", sum8, r_sum8);
      chk("sum0", sum0, r_sum0);
      chk("cnt8", cnt8, r_cnt);
      chk("cnt0", cnt0, r_cnt);
      chk("ovf8", ovf8, r_ovf8);
      chk("ovf0", ovf0, r_ovf0);
    end
  endtask

  task automatic send(input longint p, input bit last);
    int n = 0;
    in_valid = 1'b1; in_product = p; in_last = last;
    do begin
      step();
      n++;
    end while (!m_took && n < 20);
    if (!m_took) chk("accept_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic reset_all();
    rst_n = 1'b0;
    #1;
    m_out = 1'b0;
    grp.delete();
    chk("rst_valid8", out_valid8, 0);
    chk("rst_valid0", out_valid0, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_sum0", sum0, 0);
    chk("rst_cnt8", cnt8, 0);
    chk("rst_ovf0", ovf0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic signed [71:0] held8;
    rst_n = 1'b0; soft_clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_product = '0; m_out = 1'b0;
    reset_all();

    // 3, -5, 10: result visible right after the third accept
    out_ready = 1'b1;
    send(3, 0); send(-5, 0); send(10, 1);
    chk("s1_valid", out_valid8, 1);
    chk("s1_sum", sum8, 8);
    chk("s1_cnt", cnt8, 3);
    chk("s1_ovf", ovf8, 0);
    step();
    out_ready = 1'b0;

    // signed overflow wraps with no guard bits, absorbed by 8 guard bits
    send(64'sh7FFF_FFFF_FFFF_FFFF, 0); send(1, 1);
    chk("s2_sum0", sum0, 64'sh8000_0000_0000_0000);
    chk("s2_ovf0", ovf0, 1);
    chk("s2_sum8", sum8, 72'sh00_8000_0000_0000_0000);
    chk("s2_ovf8", ovf8, 0);
    retire();
    send(5, 1);
    chk("s2_next_ovf0", ovf0, 0);
    retire();

    // back-pressure: result held 5 cycles while a product waits
    send(11, 1);
    held8 = sum8;
    in_valid = 1'b1; in_product = 22; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s3_hold", sum8, held8);
    end
    out_ready = 1'b1;
    step();
    chk("s3_bubble", out_valid8, 0);
    step();
    chk("s3_taken", m_took, 1);
    chk("s3_sum", sum8, 22);
    in_valid = 1'b0; in_last = 1'b0;
    step();
    out_ready = 1'b0;

    // soft_clr discards the partial group
    send(7, 0); send(9, 0);
    soft_clr = 1'b1; step(); soft_clr = 1'b0;
    send(4, 1);
    chk("s4_sum", sum8, 4);
    chk("s4_cnt", cnt8, 1);
    retire();

    // asynchronous reset mid-group
    send(100, 0); send(200, 0);
    #2;
    reset_all();
    send(-2, 1);
    chk("s5_sum", sum8, -2);
    chk("s5_cnt", cnt8, 1);
    retire();

    // count saturation
    for (int i = 0; i < 300; i++) send(1, i == 299);
    chk("s6_cnt", cnt8, 255);
    chk("s6_sum", sum8, 300);
    retire();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_last   = ($urandom_range(4) == 0);
      out_ready = $urandom_range(1);
      soft_clr  = ($urandom_range(15) == 0);
      case ($urandom_range(3))
        0: in_product = longint'($urandom_range(2000)) - 1000;
        1: in_product = {$urandom, $urandom};
        2: in_product = $urandom_range(1) ? 64'sh7FFF_FFFF_FFFF_FFF0 : 64'sh8000_0000_0000_0010;
        default: in_product = -longint'($urandom_range(50));
      endcase
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
